wb_master_arbiter: RTL

- Shares one Wishbone single-transfer master engine between NUM_REQ on-chip requesters (CPU bridge, DMA, debug port, ...).
- Selects one requester by round-robin and latches its command.
- Drives the engine's start/address/selection/write/data_wr inputs and tracks its active output through completion.
- Returns read data plus a one-cycle done/err pulse to the granted requester.
- Sits between the requester-side logic and the master engine; the Wishbone bus signals are not touched directly.

---
 rtl/wb_master_arbiter_if.sv | 32 +++
 rtl/wb_master_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: requester-side and engine-side signals of wb_master_arbiter.
interface wb_master_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*AW-1:0]     req_addr;
   logic [NUM_REQ*DW/8-1:0]   req_sel;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*DW-1:0]     req_wdata;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        done;
   logic                      err;
   logic [DW-1:0]             rdata;
   logic                      m_start;
   logic [AW-1:0]             m_address;
   logic [DW/8-1:0]           m_selection;
   logic                      m_write;
   logic [DW-1:0]             m_data_wr;
   logic [DW-1:0]             m_data_rd;
   logic                      m_active;
   logic                      m_err;
   modport master (
      input  req, req_addr, req_sel, req_write, req_wdata, m_data_rd, m_active, m_err,
      output grant, done, err, rdata, m_start, m_address, m_selection, m_write, m_data_wr
   );
   modport slave (
      output req, req_addr, req_sel, req_write, req_wdata, m_data_rd, m_active, m_err,
      input  grant, done, err, rdata, m_start, m_address, m_selection, m_write, m_data_wr
   );
endinterface

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin sharing of one Wishbone master engine among NUM_REQ requesters.
// Define WB_MASTER_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module wb_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input logic               wb_clk,
   input logic               wb_rst_n,
   wb_master_arbiter_if.master bus
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
   state_t        state;
   logic [IW-1:0] pick;
   logic          flag;
`ifdef WB_MASTER_ARBITER_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req[k]) pick = IW'(k);
   end
`else
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] win;
   // Scan downward in offset so the nearest requester above rr_ptr is the last assignment.
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) pick = IW'((int'(rr_ptr) + k) % NUM_REQ);
   end
`endif
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state           <= IDLE;
         flag            <= 1'b0;
         bus.grant       <= '0;
         bus.done        <= '0;
         bus.err         <= 1'b0;
         bus.rdata       <= '0;
         bus.m_start     <= 1'b0;
         bus.m_address   <= '0;
         bus.m_selection <= '0;
         bus.m_write     <= 1'b0;
         bus.m_data_wr   <= '0;
`ifndef WB_MASTER_ARBITER_FIXED_PRIO_EN
         rr_ptr          <= '0;
         win             <= '0;
`endif
      end else begin
         bus.done <= '0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: if (|bus.req) begin
               bus.grant       <= NUM_REQ'(1) << pick;
               bus.m_address   <= bus.req_addr[pick*AW +: AW];
               bus.m_selection <= bus.req_sel[pick*(DW/8) +: DW/8];
               bus.m_write     <= bus.req_write[pick];
               bus.m_data_wr   <= bus.req_wdata[pick*DW +: DW];
               bus.m_start     <= 1'b1;
               flag            <= 1'b0;
`ifndef WB_MASTER_ARBITER_FIXED_PRIO_EN
               win             <= pick;
`endif
               state           <= ISSUE;
            end
            ISSUE: if (bus.m_active) begin
               bus.m_start <= 1'b0;
               state       <= BUSY;
            end
            BUSY: begin
               if (bus.m_err) flag <= 1'b1;
               if (!bus.m_active) state <= DONE;
            end
            DONE: begin
               bus.done  <= bus.grant;
               bus.err   <= flag;
               if (!bus.m_write && !flag) bus.rdata <= bus.m_data_rd;
`ifndef WB_MASTER_ARBITER_FIXED_PRIO_EN
               rr_ptr    <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
               bus.grant <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
